dbus_responder: RTL

Data-bus responder: the memory-side end of the data request/response interface driven by the pipeline memory stage. It accepts one load/store request at a time and holds a word-addressed RAM with byte-strobe writes. After a programmable wait latency it returns the full 64-bit word plus the completion handshake. It sits on the core's data bus as the simulation/FPGA data memory model.

---
 rtl/dbus_responder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dbus_responder.sv
// Data-bus responder: single-outstanding load/store memory model with a
// programmable response latency and byte-strobe writes.
// Optional feature macro: DBUS_RESP_RANDOM_STALL_EN adds 0..3 pseudo-random
// wait cycles per transaction from an 8-bit LFSR.
module dbus_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [7:0]  req_strobe,
    input  logic [63:0] req_data,
    output logic        resp_addr_ok,
    output logic        resp_data_ok,
    output logic [63:0] resp_data,
    output logic        resp_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = 5;
    localparam logic [63:0] SPAN  = 64'(DEPTH) << 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_next;
    logic [CW-1:0]       w_load;
    logic                w_capture;
    logic [1:0]          w_extra;
    logic [63:0]         r_addr;
    logic [7:0]          r_strobe;
    logic [63:0]         r_data;
    logic                r_addr_ok;
    logic                r_data_ok;
    logic [63:0]         r_rdata;
    logic                r_err;
    logic [63:0]         r_mem [DEPTH];

    logic [63:0]         w_sel_addr;
    logic [63:0]         w_rd_off;
    logic [DEPTH_LOG2-1:0] w_rd_idx;
    logic                w_rd_oor;
    logic [63:0]         w_wr_off;
    logic [DEPTH_LOG2-1:0] w_wr_idx;
    logic                w_wr_oor;
    logic                w_unused;

    // size code is informational only
    assign w_unused = ^req_size;

`ifdef DBUS_RESP_RANDOM_STALL_EN
    logic [7:0] r_lfsr;

    // Fibonacci LFSR, taps 8,6,5,4, free-running
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_extra = r_lfsr[1:0];
`else
    assign w_extra = 2'd0;
`endif

    assign w_load = CW'(LATENCY) + CW'(w_extra);

    // Read side decodes the live request when entering RESP straight from IDLE
    assign w_sel_addr = (r_state == S_IDLE) ? req_addr : r_addr;
    assign w_rd_off   = w_sel_addr - BASE_ADDR;
    assign w_rd_idx   = w_rd_off[DEPTH_LOG2+2:3];
    assign w_rd_oor   = (w_sel_addr < BASE_ADDR) || (w_rd_off >= SPAN);

    // Write side always uses the captured request
    assign w_wr_off = r_addr - BASE_ADDR;
    assign w_wr_idx = w_wr_off[DEPTH_LOG2+2:3];
    assign w_wr_oor = (r_addr < BASE_ADDR) || (w_wr_off >= SPAN);

    // State and wait-counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and counter logic
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_capture  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_capture  = 1'b1;
                    w_cnt_next = w_load;
                    w_next     = (w_load == '0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request capture; inputs are ignored outside the capture edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr   <= '0;
            r_strobe <= '0;
            r_data   <= '0;
        end else if (w_capture) begin
            r_addr   <= req_addr;
            r_strobe <= req_strobe;
            r_data   <= req_data;
        end
    end

    // Response outputs, registered on entry to RESP so they last one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr_ok <= 1'b0;
            r_data_ok <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_addr_ok <= (w_next == S_RESP);
            r_data_ok <= (w_next == S_RESP);
            r_rdata   <= ((w_next == S_RESP) && !w_rd_oor) ? r_mem[w_rd_idx] : 64'd0;
            r_err     <= (w_next == S_RESP) && w_rd_oor;
        end
    end

    // Byte-lane write at the closing edge of RESP; RAM is never cleared
    always_ff @(posedge clk) begin
        if ((r_state == S_RESP) && !w_wr_oor && !reset) begin
            for (int i = 0; i < 8; i++) begin
                if (r_strobe[i]) begin
                    r_mem[w_wr_idx][8*i +: 8] <= r_data[8*i +: 8];
                end
            end
        end
    end

    assign resp_addr_ok = r_addr_ok;
    assign resp_data_ok = r_data_ok;
    assign resp_data    = r_rdata;
    assign resp_err     = r_err;

endmodule
